// File: rtl/perf_run_ctrl.sv
// Run controller for the simulation harness: sequences IDLE/RUN/DRAIN/DONE and
// keeps saturating cycle, retired-instruction and stall counters behind a registered readout.
module perf_run_ctrl #(
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 100000,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             isHalt,
  input  logic             W_v,
  input  logic             stall,
  input  logic [1:0]       rd_sel,
  output logic [CNT_W-1:0] rd_data,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int DC_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DC_W-1:0] DRAIN_LD = DC_W'(DRAIN_CYCLES);
  localparam logic [CNT_W:0]  MAX_C    = (CNT_W + 1)'(MAX_CYCLES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] insn_q, insn_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             timeout_q, timeout_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic [DC_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  logic [CNT_W-1:0] status;
  logic             at_limit;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

  // Extra bit so a limit at 2^CNT_W can never alias onto a wrapped compare.
  assign at_limit = (({1'b0, cycle_q} + {{CNT_W{1'b0}}, 1'b1}) == MAX_C);

  always_comb begin
    state_d     = state_q;
    cycle_d     = cycle_q;
    insn_d      = insn_q;
    stall_cnt_d = stall_cnt_q;
    timeout_d   = timeout_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          cycle_d     = '0;
          insn_d      = '0;
          stall_cnt_d = '0;
          timeout_d   = 1'b0;
          drain_cnt_d = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        cycle_d     = sat_inc(cycle_q, 1'b1);
        insn_d      = sat_inc(insn_q, W_v);
        stall_cnt_d = sat_inc(stall_cnt_q, stall);
        if (isHalt) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = DRAIN_LD;
          end
        end else if (at_limit) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      S_DRAIN: begin
        insn_d      = sat_inc(insn_q, W_v);
        drain_cnt_d = drain_cnt_q - 1'b1;
        if (drain_cnt_q == DC_W'(1)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign running_d = (state_d == S_RUN) || (state_d == S_DRAIN);
  assign done_d    = (state_d == S_DONE);

  always_comb begin
    status      = '0;
    status[0]   = running_q;
    status[1]   = done_q;
    status[2]   = timeout_q;
    status[4:3] = state_q;
  end

  always_comb begin
    rd_data_d = status;
    case (rd_sel)
      2'd0:    rd_data_d = cycle_q;
      2'd1:    rd_data_d = insn_q;
      2'd2:    rd_data_d = stall_cnt_q;
      default: rd_data_d = status;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cycle_q     <= '0;
      insn_q      <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      drain_cnt_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      cycle_q     <= cycle_d;
      insn_q      <= insn_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
      running_q   <= running_d;
      done_q      <= done_d;
      drain_cnt_q <= drain_cnt_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;
  assign running = running_q;
  assign done    = done_q;
  assign timeout = timeout_q;
  assign cycle   = cycle_q;

endmodule

// File: tb/tb_perf_run_ctrl.sv
// Bench for perf_run_ctrl: two instances (4-cycle drain / 32-bit, no drain / 5-bit
// saturating) driven in parallel and compared every cycle against a run-level model.
module tb_perf_run_ctrl;

  localparam int  MAXC  = 20;
  localparam int  WA    = 32;
  localparam int  WB    = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0, isHalt = 1'b0, W_v = 1'b0, stall = 1'b0;
  logic [1:0] rd_sel = 2'd0;
  logic [WA-1:0] rd_a, cyc_a;
  logic [WB-1:0] rd_b, cyc_b;
  logic run_a, done_a, to_a, run_b, done_b, to_b;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  perf_run_ctrl #(.CNT_W(WA), .MAX_CYCLES(MAXC), .DRAIN_CYCLES(4)) u_a (
    .clk(clk), .reset(reset), .start(start), .isHalt(isHalt), .W_v(W_v), .stall(stall),
    .rd_sel(rd_sel), .rd_data(rd_a), .running(run_a), .done(done_a), .timeout(to_a), .cycle(cyc_a));

  perf_run_ctrl #(.CNT_W(WB), .MAX_CYCLES(100), .DRAIN_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .start(start), .isHalt(isHalt), .W_v(W_v), .stall(stall),
    .rd_sel(rd_sel), .rd_data(rd_b), .running(run_b), .done(done_b), .timeout(to_b), .cycle(cyc_b));

  // Run-level model: phase 0 idle, 1 run, 2 drain, 3 done.
  typedef struct {
    int     st;
    longint cyc, ins, stl;
    bit     to;
    int     dc;
    longint rd;
  } mdl_t;

  mdl_t ma, mb;

  function automatic longint capped(longint v, longint smax);
    return (v > smax) ? smax : v;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit s, bit h, bit w, bit sv, int sel,
                                 longint maxc, int drc, longint smax);
    mdl_t n = m;
    case (sel)
      0: n.rd = m.cyc;
      1: n.rd = m.ins;
      2: n.rd = m.stl;
      default: n.rd = ((m.st == 1 || m.st == 2) ? 1 : 0) + ((m.st == 3) ? 2 : 0)
                      + (m.to ? 4 : 0) + m.st * 8;
    endcase
    if (m.st == 0 || m.st == 3) begin
      if (s) begin
        n.cyc = 0; n.ins = 0; n.stl = 0; n.to = 0; n.dc = 0; n.st = 1;
      end
    end else if (m.st == 1) begin
      n.cyc = capped(m.cyc + 1, smax);
      n.ins = capped(m.ins + w, smax);
      n.stl = capped(m.stl + sv, smax);
      if (h) begin
        if (drc == 0) n.st = 3;
        else begin n.st = 2; n.dc = drc; end
      end else if (m.cyc + 1 == maxc) begin
        n.st = 3; n.to = 1;
      end
    end else begin
      n.ins = capped(m.ins + w, smax);
      if (m.dc == 1) n.st = 3;
      else n.dc = m.dc - 1;
    end
    return n;
  endfunction

  function automatic mdl_t mreset();
    mdl_t z = '{st: 0, cyc: 0, ins: 0, stl: 0, to: 0, dc: 0, rd: 0};
    return z;
  endfunction

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("a.cycle",   cyc_a,  ma.cyc);
    chk("a.running", run_a,  (ma.st == 1 || ma.st == 2) ? 1 : 0);
    chk("a.done",    done_a, (ma.st == 3) ? 1 : 0);
    chk("a.timeout", to_a,   ma.to);
    chk("a.rd_data", rd_a,   ma.rd);
    chk("b.cycle",   cyc_b,  mb.cyc);
    chk("b.running", run_b,  (mb.st == 1 || mb.st == 2) ? 1 : 0);
    chk("b.done",    done_b, (mb.st == 3) ? 1 : 0);
    chk("b.timeout", to_b,   mb.to);
    chk("b.rd_data", rd_b,   mb.rd);
  endtask

  task automatic tick(input bit s, input bit h, input bit w, input bit sv, input int sel);
    start = s; isHalt = h; W_v = w; stall = sv; rd_sel = sel[1:0];
    @(posedge clk);
    ma = mstep(ma, s, h, w, sv, sel, MAXC, 4, 64'hFFFF_FFFF);
    mb = mstep(mb, s, h, w, sv, sel, 100, 0, 31);
    #1;
    chk_all();
  endtask

  initial begin
    ma = mreset();
    mb = mreset();
    #12;
    chk_all();
    reset = 1'b0;

    // Basic run: 10 RUN cycles, W_v on 1-6, stall on 7-9, halt on 10.
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 10; i++) tick(0, i == 10, i <= 6, i >= 7 && i <= 9, 0);
    for (int i = 0; i < 4; i++) tick(0, 0, i < 2, 0, 0);
    chk("basic.done", done_a, 1);
    chk("basic.timeout", to_a, 0);
    tick(0, 0, 0, 0, 0); chk("basic.cycle", rd_a, 10);
    tick(0, 0, 0, 0, 1); chk("basic.insn", rd_a, 8);
    tick(0, 0, 0, 0, 2); chk("basic.stall", rd_a, 3);
    tick(0, 0, 0, 0, 3); chk("basic.status", rd_a, 'h1A);
    chk("nodrain.insn_ignores_drain_wv", mb.ins, 6);

    // Restart from DONE, then halt on RUN cycle 5 (no-drain instance finishes at once).
    tick(1, 0, 0, 0, 0);
    chk("restart.cycle", cyc_a, 0);
    tick(0, 0, 1, 0, 1);
    chk("restart.insn_rd", rd_a, 0);
    for (int i = 2; i <= 5; i++) tick(0, i == 5, 1, 0, 1);
    chk("nodrain.done", done_b, 1);
    chk("nodrain.cycle", cyc_b, 5);
    tick(0, 0, 1, 0, 1);
    tick(0, 0, 1, 0, 1);
    chk("nodrain.insn_frozen", rd_b, 5);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0, 3);

    // Timeout at MAX_CYCLES; second instance keeps running into saturation.
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) tick(0, 0, 1, 0, 0);
    chk("timeout.done", done_a, 1);
    chk("timeout.flag", to_a, 1);
    chk("timeout.cycle", cyc_a, 20);
    for (int i = 0; i < 15; i++) tick(0, 0, 1, 1, 3);
    chk("timeout.cycle_held", cyc_a, 20);
    chk("sat.cycle", cyc_b, 31);

    // Halt on the same cycle the limit would fire: halt wins.
    tick(1, 0, 0, 0, 0);
    for (int i = 1; i <= 19; i++) tick(0, 0, 0, 0, 0);
    tick(0, 1, 0, 0, 3);
    chk("simul.running", run_a, 1);
    chk("simul.done", done_a, 0);
    chk("simul.timeout", to_a, 0);
    chk("simul.cycle", cyc_a, 20);
    for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 3);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++)
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)));

    // Async reset in the middle of DRAIN.
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 1);
    tick(0, 1, 1, 0, 1);
    tick(0, 0, 1, 0, 1);
    chk("rst.pre_drain", run_a, 1);
    #3;
    reset = 1'b1;
    #1;
    ma = mreset();
    mb = mreset();
    chk_all();
    chk("rst.cycle", cyc_a, 0);
    chk("rst.rd", rd_a, 0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick(0, 1, 1, 1, 0);
    chk("rst.idle_cycle", cyc_a, 0);
    chk("rst.idle_running", run_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
